// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Registers update on the falling clock edge; ready toward EX comes straight from state.
module ex_mem_skid_stage #(
    parameter int LANES  = 8,
    parameter int EW     = 24,
    parameter int SW     = 21,
    parameter int MEM_W  = 5,
    parameter int WB_W   = 2,
    parameter int DEST_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MEM_W-1:0]      mem,
    input  logic [WB_W-1:0]       wb,
    input  logic [SW-1:0]         r1e,
    input  logic [SW-1:0]         r2e,
    input  logic [LANES*EW-1:0]   r1v,
    input  logic [LANES*EW-1:0]   r2v,
    input  logic [SW-1:0]         res_alu_e,
    input  logic [LANES*EW-1:0]   res_alu_ve,
    input  logic [LANES*EW-1:0]   res_sum,
    input  logic [DEST_W-1:0]     dest,
    input  logic                  dest_type,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MEM_W-1:0]      mem_out,
    output logic [WB_W-1:0]       wb_out,
    output logic [SW-1:0]         r1e_out,
    output logic [SW-1:0]         r2e_out,
    output logic [LANES*EW-1:0]   r1v_out,
    output logic [LANES*EW-1:0]   r2v_out,
    output logic [SW-1:0]         res_alu_e_out,
    output logic [LANES*EW-1:0]   res_alu_ve_out,
    output logic [LANES*EW-1:0]   res_sum_out,
    output logic [DEST_W-1:0]     dest_out,
    output logic                  dest_type_out,
    output logic [1:0]            occ
);

    localparam int VW = LANES * EW;
    localparam int PW = MEM_W + WB_W + 3 * SW + 4 * VW + DEST_W + 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   in_bundle;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic            in_fire;
    logic            out_fire;
    logic            load_main_in;
    logic            load_main_skid;
    logic            load_skid;

    // All payload fields travel as one flat word; main_q is the head of the FIFO.
    assign in_bundle = {mem, wb, r1e, r2e, r1v, r2v, res_alu_e, res_alu_ve, res_sum,
                        dest, dest_type};
    assign {mem_out, wb_out, r1e_out, r2e_out, r1v_out, r2v_out, res_alu_e_out,
            res_alu_ve_out, res_sum_out, dest_out, dest_type_out} = main_q;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign occ       = {state == FULL, state == ONE};
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nx     = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_nx  = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nx = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so the skid entry simply advances to the head.
                    if (out_fire) begin
                        state_nx       = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Payload only moves on handshake events; a flush leaves stale data behind.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_bundle;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_bundle;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Randomised and directed bench for ex_mem_skid_stage; a queue of accepted bundles
// (capacity 2) is the reference, and a monitor compares the DUT against its head.
module tb_ex_mem_skid_stage;

    localparam int LANES  = 4;
    localparam int EW     = 16;
    localparam int SW     = 21;
    localparam int MEM_W  = 5;
    localparam int WB_W   = 2;
    localparam int DEST_W = 4;
    localparam int VW     = LANES * EW;

    typedef struct packed {
        logic [MEM_W-1:0]  mem;
        logic [WB_W-1:0]   wb;
        logic [SW-1:0]     r1e;
        logic [SW-1:0]     r2e;
        logic [VW-1:0]     r1v;
        logic [VW-1:0]     r2v;
        logic [SW-1:0]     res_alu_e;
        logic [VW-1:0]     res_alu_ve;
        logic [VW-1:0]     res_sum;
        logic [DEST_W-1:0] dest;
        logic              dest_type;
    } bundle_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    bundle_t in_b = '0;
    bundle_t out_b;

    logic              in_ready;
    logic              out_valid;
    logic [1:0]        occ;
    logic [MEM_W-1:0]  mem_out;
    logic [WB_W-1:0]   wb_out;
    logic [SW-1:0]     r1e_out;
    logic [SW-1:0]     r2e_out;
    logic [VW-1:0]     r1v_out;
    logic [VW-1:0]     r2v_out;
    logic [SW-1:0]     res_alu_e_out;
    logic [VW-1:0]     res_alu_ve_out;
    logic [VW-1:0]     res_sum_out;
    logic [DEST_W-1:0] dest_out;
    logic              dest_type_out;

    bundle_t sb[$];
    int      checks = 0;
    int      errors = 0;
    bit      mon_en = 1'b0;

    ex_mem_skid_stage #(
        .LANES(LANES), .EW(EW), .SW(SW), .MEM_W(MEM_W), .WB_W(WB_W), .DEST_W(DEST_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem(in_b.mem), .wb(in_b.wb), .r1e(in_b.r1e), .r2e(in_b.r2e),
        .r1v(in_b.r1v), .r2v(in_b.r2v), .res_alu_e(in_b.res_alu_e),
        .res_alu_ve(in_b.res_alu_ve), .res_sum(in_b.res_sum),
        .dest(in_b.dest), .dest_type(in_b.dest_type),
        .out_valid(out_valid), .out_ready(out_ready),
        .mem_out(mem_out), .wb_out(wb_out), .r1e_out(r1e_out), .r2e_out(r2e_out),
        .r1v_out(r1v_out), .r2v_out(r2v_out), .res_alu_e_out(res_alu_e_out),
        .res_alu_ve_out(res_alu_ve_out), .res_sum_out(res_sum_out),
        .dest_out(dest_out), .dest_type_out(dest_type_out), .occ(occ)
    );

    assign out_b = {mem_out, wb_out, r1e_out, r2e_out, r1v_out, r2v_out, res_alu_e_out,
                    res_alu_ve_out, res_sum_out, dest_out, dest_type_out};

    always #5 clk = ~clk;

    function automatic bundle_t randBundle();
        bundle_t b;
        b.mem        = MEM_W'($urandom());
        b.wb         = WB_W'($urandom());
        b.r1e        = SW'($urandom());
        b.r2e        = SW'($urandom());
        b.r1v        = VW'({$urandom(), $urandom()});
        b.r2v        = VW'({$urandom(), $urandom()});
        b.res_alu_e  = SW'($urandom());
        b.res_alu_ve = VW'({$urandom(), $urandom()});
        b.res_sum    = VW'({$urandom(), $urandom()});
        b.dest       = DEST_W'($urandom());
        b.dest_type  = 1'($urandom());
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBundle(input string name, input bundle_t act, input bundle_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at posedge+2, record acceptance from the reference's occupancy,
    // and update the reference just before the falling edge where the DUT acts.
    task automatic applyStimulus(input bit v, input bundle_t b, input bit ordy,
                                 input bit fl, output bit acc);
        @(posedge clk);
        #2;
        in_valid  = v;
        in_b      = b;
        out_ready = ordy;
        flush     = fl;
        acc       = v && !fl && (sb.size() < 2);
        #2;
        if (fl) begin
            sb.delete();
        end else if (acc) begin
            sb.push_back(b);
        end
    endtask

    task automatic sendUntil(input bundle_t b, input bit ordy);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            applyStimulus(1'b1, b, ordy, 1'b0, acc);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL send timeout: got not-accepted expected accepted dest %0h", b.dest);
        end
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, randBundle(), 1'b1, 1'b0, acc);
        end
    endtask

    // Monitor: compares flags against the reference depth and the head payload every
    // cycle, and retires the head when MEM takes it.
    initial begin : monitor
        int n;
        forever begin
            @(posedge clk);
            #3;
            if (mon_en) begin
                n = sb.size();
                checkOutput("occ", 64'(occ), 64'(n));
                checkOutput("out_valid", 64'(out_valid), 64'(n > 0));
                checkOutput("in_ready", 64'(in_ready), 64'(n < 2));
                if (n > 0) begin
                    checkBundle("payload", out_b, sb[0]);
                    if (out_ready && !flush) begin
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin : main
        bundle_t b;
        bit      acc;

        // Reset held with a valid bundle offered: nothing may be captured.
        in_valid  = 1'b1;
        in_b      = randBundle();
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        checkOutput("reset occ", 64'(occ), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkBundle("reset payload", out_b, '0);
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Basic single transfer, visible right after the capturing edge.
        b = randBundle();
        b.dest = 4'h3;
        b.res_alu_e = 21'h1ABCD;
        applyStimulus(1'b1, b, 1'b1, 1'b0, acc);
        #2;
        checkOutput("basic out_valid", 64'(out_valid), 64'd1);
        checkOutput("basic dest", 64'(dest_out), 64'h3);
        checkOutput("basic res_alu_e", 64'(res_alu_e_out), 64'h1ABCD);
        drain();

        // Back-to-back streaming at full rate.
        for (int i = 0; i < 10; i++) begin
            b = randBundle();
            b.dest = DEST_W'(i);
            applyStimulus(1'b1, b, 1'b1, 1'b0, acc);
            #2;
            checkOutput("stream dest", 64'(dest_out), 64'(i));
            checkOutput("stream occ", 64'(occ), 64'd1);
            checkOutput("stream in_ready", 64'(in_ready), 64'd1);
        end
        drain();

        // Stall: two bundles fill the stage, the third waits upstream.
        for (int i = 1; i <= 2; i++) begin
            b = randBundle();
            b.dest = DEST_W'(i);
            applyStimulus(1'b1, b, 1'b0, 1'b0, acc);
            #2;
            checkOutput("stall occ", 64'(occ), 64'(i));
        end
        checkOutput("stall in_ready", 64'(in_ready), 64'd0);
        b = randBundle();
        b.dest = 4'h3;
        applyStimulus(1'b1, b, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, b, 1'b0, 1'b0, acc);
        #2;
        checkOutput("stall held dest", 64'(dest_out), 64'h1);
        sendUntil(b, 1'b1);
        drain();

        // Flush from FULL while a new bundle and an MEM accept are both offered.
        for (int i = 5; i <= 6; i++) begin
            b = randBundle();
            b.dest = DEST_W'(i);
            applyStimulus(1'b1, b, 1'b0, 1'b0, acc);
        end
        b = randBundle();
        b.dest = 4'h7;
        applyStimulus(1'b1, b, 1'b1, 1'b1, acc);
        #2;
        checkOutput("flush occ", 64'(occ), 64'd0);
        checkOutput("flush out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush in_ready", 64'(in_ready), 64'd1);
        drain();

        // Wide vector payload and vector destination type.
        b = randBundle();
        b.res_sum = 64'hDEAD_BEEF_0123_4567;
        b.dest_type = 1'b1;
        applyStimulus(1'b1, b, 1'b1, 1'b0, acc);
        #2;
        checkOutput("wide res_sum", 64'(res_sum_out), 64'hDEAD_BEEF_0123_4567);
        checkOutput("wide dest_type", 64'(dest_type_out), 64'd1);
        drain();

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randBundle(),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, acc);
        end
        drain();

        // Asynchronous reset while FULL, between clock edges.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, randBundle(), 1'b0, 1'b0, acc);
        end
        #2;
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async occ", 64'(occ), 64'd0);
        checkOutput("async out_valid", 64'(out_valid), 64'd0);
        checkOutput("async in_ready", 64'(in_ready), 64'd1);
        checkBundle("async payload", out_b, '0);
        sb.delete();
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus($urandom_range(0, 1) != 0, randBundle(),
                          $urandom_range(0, 1) != 0, 1'b0, acc);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
